// File: rtl/uart_tx_param.sv
`default_nettype none
// =============================================================================
// Module   : uart_tx_param
// Desc     : Parametrised UART transmitter with a small input FIFO. Queued
//            words are serialised LSB-first onto an idle-high line using a
//            configurable frame: start bit, DATA_BITS data bits, optional
//            odd/even parity bit, one or two stop bits. Frames run
//            back-to-back with no idle gap while the FIFO holds data.
// Ports    : clk        - system clock, all logic on the rising edge
//            rst_n      - synchronous active-low reset
//            data       - word to transmit (DATA_BITS wide)
//            data_en    - write strobe, accepted when data_ready is high
//            data_ready - FIFO not full (combinational from FIFO count)
//            trans      - serial line, idle high (registered)
//            trans_busy - a frame is on the line (registered)
//            fifo_count - number of queued words
//            overflow   - sticky, a write was attempted while full
// Revision : 1.0 - initial release
// =============================================================================
module uart_tx_param #(
  parameter int CLK_DIV    = 434,  // clock cycles per bit, 2..65535
  parameter int DATA_BITS  = 8,    // data bits per frame, 5..9
  parameter int PARITY     = 0,    // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS  = 1,    // 1 or 2
  parameter int FIFO_DEPTH = 4     // power of two, 2..64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        data,
  input  logic                        data_en,
  output logic                        data_ready,
  output logic                        trans,
  output logic                        trans_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_BAUD_W = $clog2(CLK_DIV);
  localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
  localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [c_BAUD_W-1:0]  r_baud;
  logic [c_BIT_W-1:0]   r_bit;
  logic                 r_par;
  logic                 r_trans;
  logic                 r_busy;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic                 w_push;
  logic                 w_ovf_set;
  logic                 w_load;
  logic                 w_baud_end;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_par;

  state_t               w_state_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [c_BAUD_W-1:0]  w_baud_nxt;
  logic [c_BIT_W-1:0]   w_bit_nxt;
  logic                 w_par_nxt;
  logic                 w_trans_nxt;

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  assign data_ready = (r_count != c_FULL);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // A write while full is dropped even if a pop happens in the same cycle,
  // because data_ready is derived from the count before that pop.
  assign w_push    = data_en & data_ready;
  assign w_ovf_set = data_en & ~data_ready;

  assign w_head     = r_mem[r_rd_ptr];
  // Even parity bit is the XOR of the word; odd parity is its complement.
  assign w_head_par = (PARITY == 2) ? (^w_head) : ~(^w_head);

  assign w_baud_end = (r_baud == c_BAUD_LAST);

  // ---------------------------------------------------------------------------
  // Frame sequencer: next state, counters and shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_par_nxt   = r_par;
    w_load      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load = 1'b1;
        end
      end

      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt = r_baud + c_BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == c_DATA_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt   = r_bit + c_BIT_W'(1);
            w_shift_nxt = r_shift >> 1;
          end
        end else begin
          w_baud_nxt = r_baud + c_BAUD_W'(1);
        end
      end

      S_PARITY: begin
        if (w_baud_end) begin
          w_state_nxt = S_STOP;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt = r_baud + c_BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == c_STOP_LAST) begin
            w_bit_nxt = '0;
            // Chain straight into the next start bit when data is queued.
            if (r_count != '0) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_bit_nxt = r_bit + c_BIT_W'(1);
          end
        end else begin
          w_baud_nxt = r_baud + c_BAUD_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase

    // Loading pops the FIFO head and starts a fresh frame.
    if (w_load) begin
      w_state_nxt = S_START;
      w_shift_nxt = w_head;
      w_par_nxt   = w_head_par;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
    end
  end

  // The line value is decoded from the next state so that trans is a plain
  // register output that changes on the same edge as the state.
  always_comb begin
    w_trans_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_trans_nxt = 1'b0;
      S_DATA:   w_trans_nxt = w_shift_nxt[0];
      S_PARITY: w_trans_nxt = w_par_nxt;
      default:  w_trans_nxt = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_par      <= 1'b0;
      r_trans    <= 1'b1;
      r_busy     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_par   <= w_par_nxt;
      r_trans <= w_trans_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end

      case ({w_push, w_load})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  assign trans      = r_trans;
  assign trans_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_tx_param
// Desc     : Self-checking bench for uart_tx_param. Four differently
//            configured instances share one clock. For each, a driver issues
//            directed and random writes; a reference model predicts which
//            writes are accepted, when each frame starts and how full the
//            FIFO is, and pushes expected frames into a scoreboard queue.
//            A monitor pops a frame whenever the line goes busy and checks
//            every line cycle, plus FIFO status and the overflow flag.
// Revision : 1.0 - initial release
// =============================================================================
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [8:0] word;
    int         p;  // edge at which the word enters the FIFO
    int         s;  // edge at which its start bit begins
  } rec_t;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cfg %0d) at t=%0t: got %0h, expected %0h",
               name, inst, $time, act, exp);
    end
  endtask

  // Line value of frame bit k: start, data LSB-first, optional parity, stops.
  function automatic logic exp_bit(input logic [8:0] word, input int k,
                                   input int db, input int par);
    int ones;
    ones = $countones(word);
    if (k == 0) return 1'b0;
    if (k <= db) return word[k-1];
    if (par != 0 && k == db + 1) begin
      if (par == 2) return ((ones % 2) == 1);
      return ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DIV = (g == 0) ? 4 : (g == 1) ? 4 : (g == 2) ? 3 : 5;
    localparam int DB  = (g == 3) ? 5 : 8;
    localparam int PAR = (g == 1) ? 2 : (g == 2) ? 1 : 0;
    localparam int SB  = (g == 1) ? 2 : 1;
    localparam int DEP = (g == 2) ? 2 : (g == 3) ? 8 : 4;
    localparam int W0  = (g == 0) ? 'hA5 : (g == 3) ? 'h1F : 'h07;
    localparam int FL  = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * DIV;

    localparam int C_B   = 10 + 2 * FL;
    localparam int C_R   = C_B + 8 * FL;
    localparam int C_X   = C_R + 6 * FL;
    localparam int C_Y   = C_X + 3 * DIV + 2 * FL;
    localparam int C_MID = C_Y + 20 * FL;
    localparam int C_Z   = C_Y + 40 * FL;

    logic                  rst_n;
    logic [DB-1:0]         data;
    logic                  data_en;
    logic                  data_ready;
    logic                  trans;
    logic                  trans_busy;
    logic [$clog2(DEP):0]  fifo_count;
    logic                  overflow;

    rec_t all_q[$];
    rec_t exp_q[$];
    int   last_s;
    int   ovf_edge;
    bit   flush;
    bit   in_fr;
    bit   done;

    uart_tx_param #(
      .CLK_DIV   (DIV),
      .DATA_BITS (DB),
      .PARITY    (PAR),
      .STOP_BITS (SB),
      .FIFO_DEPTH(DEP)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .data_en   (data_en),
      .data_ready(data_ready),
      .trans     (trans),
      .trans_busy(trans_busy),
      .fifo_count(fifo_count),
      .overflow  (overflow)
    );

    // Driver and reference model: decisions made at negedge for next edge.
    initial begin : drv
      logic [31:0] w;
      logic        en;
      int          e, occ, p, s;
      rec_t        r;
      last_s   = -1000000;
      ovf_edge = 1 << 30;
      flush    = 1'b0;
      done     = 1'b0;
      rst_n    = 1'b0;
      data_en  = 1'b0;
      data     = '0;
      for (int c = 0; c < C_Z; c++) begin
        @(negedge clk);
        e     = edge_n;
        en    = 1'b0;
        w     = $urandom;
        rst_n = 1'b1;
        if (c < 3) rst_n = 1'b0;
        else if (c == 4) begin en = 1'b1; w = W0; end
        else if (c >= C_B && c < C_B + 6) begin
          en = 1'b1; w = 32'h11 * (c - C_B + 1);
        end
        else if (c >= C_R && c < C_R + 3) begin
          en = 1'b1; w = 32'h40 + 32'(c - C_R);
        end
        // Lands on the edge where the first frame of this group ends.
        else if (c == C_R + 1 + FL) begin en = 1'b1; w = 32'h4F; end
        else if (c >= C_X && c < C_X + 3) begin
          en = 1'b1; w = (c == C_X) ? 32'h3C : 32'h5A + 32'(c);
        end
        else if (c == C_X + 1 + 3 * DIV || c == C_X + 2 + 3 * DIV) rst_n = 1'b0;
        else if (c == C_MID) rst_n = 1'b0;
        else if (c >= C_Y) begin
          en = ((((c - C_Y) / (2 * FL)) % 3) != 2) && ($urandom_range(0, 3) != 0);
        end

        data_en = en;
        data    = w[DB-1:0];
        if (!rst_n) begin
          data_en  = 1'b0;
          all_q.delete();
          exp_q.delete();
          last_s   = -1000000;
          ovf_edge = 1 << 30;
          flush    = 1'b1;
        end else if (en) begin
          occ = 0;
          foreach (all_q[i]) if (all_q[i].p <= e && all_q[i].s > e) occ++;
          if (occ < DEP) begin
            p = e + 1;
            s = (p + 1 > last_s + FL) ? p + 1 : last_s + FL;
            last_s = s;
            r.word = '0;
            r.word[DB-1:0] = w[DB-1:0];
            r.p = p;
            r.s = s;
            all_q.push_back(r);
            exp_q.push_back(r);
          end else if (ovf_edge > e + 1) begin
            ovf_edge = e + 1;
          end
        end
      end
      data_en = 1'b0;
      for (int k = 0; k < 30 * FL && (exp_q.size() != 0 || in_fr); k++) @(negedge clk);
      check("drain_queue", g, 32'(exp_q.size()), 0);
      check("drain_idle", g, 32'(in_fr), 0);
      done = 1'b1;
    end

    // Monitor: samples one time unit after each rising edge.
    initial begin : mon
      rec_t cur;
      int   e, occ, idx;
      in_fr = 1'b0;
      idx   = 0;
      cur.word = '0; cur.p = 0; cur.s = 0;
      forever begin
        @(posedge clk);
        #1;
        e = edge_n;
        if (flush) begin
          in_fr = 1'b0;
          flush = 1'b0;
        end
        occ = 0;
        foreach (all_q[i]) if (all_q[i].p <= e && all_q[i].s > e) occ++;
        check("fifo_count", g, 32'(fifo_count), occ);
        check("data_ready", g, 32'(data_ready), (occ < DEP) ? 1 : 0);
        check("overflow", g, 32'(overflow), (ovf_edge <= e) ? 1 : 0);

        if (!in_fr && trans_busy === 1'b1) begin
          check("frame_expected", g, 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("start_edge", g, e, cur.s);
            in_fr = 1'b1;
            idx   = 0;
          end
        end

        if (in_fr) begin
          check("trans_bit", g, 32'(trans), 32'(exp_bit(cur.word, idx / DIV, DB, PAR)));
          check("busy_in_frame", g, 32'(trans_busy), 1);
          idx++;
          if (idx == FL) in_fr = 1'b0;
        end else begin
          check("idle_line", g, 32'(trans), 1);
        end
      end
    end
  end

  initial begin : summary
    int waited;
    logic all_done;
    waited   = 0;
    all_done = 1'b0;
    while (!all_done && waited < 20000) begin
      @(posedge clk);
      waited++;
      all_done = g_cfg[0].done & g_cfg[1].done & g_cfg[2].done & g_cfg[3].done;
    end
    check("all_done", 0, 32'(all_done), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
